// File: rtl/aes_feed_pkg.sv
// Shared constants, FSM state and core request type for the AES word feeder.
package aes_feed_pkg;
  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int WC_W            = $clog2(WORDS_PER_BLOCK);
  localparam int INFL_W          = 5;

  typedef enum logic {COLLECT, PEND} feed_state_e;

  typedef struct packed {
    logic [BLOCK_W-1:0] pt;
    logic [BLOCK_W-1:0] key;
  } core_req_t;

  // Slot 0 lands in the most significant word of the block.
  function automatic logic [BLOCK_W-1:0] put_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [WC_W-1:0]    slot,
                                                  input logic [WORD_W-1:0]  w);
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[BLOCK_W-1 - int'(slot)*WORD_W -: WORD_W] = w;
    return r;
  endfunction
endpackage

// File: rtl/aes_word_feeder_if.sv
// Bus bundle between the feeder and its neighbours (word source, AES core, consumer).
interface aes_word_feeder_if;
  import aes_feed_pkg::*;

  logic                key_load;
  logic [BLOCK_W-1:0]  key_in;
  logic                in_valid;
  logic                in_ready;
  logic [WORD_W-1:0]   in_data;
  logic [BLOCK_W-1:0]  core_state;
  logic [BLOCK_W-1:0]  core_key;
  logic [BLOCK_W-1:0]  core_out;
  logic                out_valid;
  logic                out_ready;
  logic [BLOCK_W-1:0]  out_data;
  logic [INFL_W-1:0]   inflight;

  modport slave (
    input  key_load, key_in, in_valid, in_data, core_out, out_ready,
    output in_ready, core_state, core_key, out_valid, out_data, inflight
  );

  modport master (
    output key_load, key_in, in_valid, in_data, core_out, out_ready,
    input  in_ready, core_state, core_key, out_valid, out_data, inflight
  );
endinterface

// File: rtl/aes_out_fifo.sv
// Show-ahead result FIFO: head is always visible, count reports occupancy.
module aes_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers define what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/aes_word_feeder.sv
// Packs plaintext words into blocks, issues them to a non-stalling AES core
// under credit control, and buffers the results in a show-ahead FIFO.
module aes_word_feeder
  import aes_feed_pkg::*;
#(
  parameter int CORE_LATENCY = 21,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  aes_word_feeder_if.slave  bus
);
  localparam int STAGES = CORE_LATENCY - 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W  = INFL_W + 1;

  feed_state_e        state_q, state_d;
  logic [WC_W-1:0]    wc_q;
  logic [BLOCK_W-1:0] blk_q;
  logic [BLOCK_W-1:0] key_q;
  core_req_t          core_q;
  logic [STAGES:0]    vld_pipe;
  logic [INFL_W-1:0]  inflight_q;
  logic               live_q;
  logic [CNT_W-1:0]   fifo_count;
  logic               accept, issue, capture, credit_ok, in_ready_c;

  // Every issued block owns a FIFO slot until it is popped, so capture never overflows.
  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
  assign capture   = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    issue      = 1'b0;
    in_ready_c = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready_c = live_q;
        accept     = live_q & bus.in_valid;
        if (accept && wc_q == WC_W'(WORDS_PER_BLOCK-1)) state_d = PEND;
      end
      PEND: begin
        issue = credit_ok;
        if (credit_ok) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // live_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= 1'b0;
      wc_q   <= '0;
      blk_q  <= '0;
      key_q  <= '0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        wc_q  <= wc_q + 1'b1;
        blk_q <= put_word(blk_q, wc_q, bus.in_data);
      end
      if (bus.key_load) key_q <= bus.key_in;
    end
  end

  // key_q is sampled before a same-edge key_load lands, so the issued block keeps the old key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_q     <= '0;
      vld_pipe   <= '0;
      inflight_q <= '0;
    end else begin
      if (issue) core_q <= '{pt: blk_q, key: key_q};
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      case ({issue, capture})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  aes_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BLOCK_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (bus.core_out),
    .pop       (bus.out_ready),
    .head      (bus.out_data),
    .count     (fifo_count)
  );

  assign bus.in_ready   = in_ready_c;
  assign bus.core_state = core_q.pt;
  assign bus.core_key   = core_q.key;
  assign bus.out_valid  = (fifo_count != '0);
  assign bus.inflight   = inflight_q;

  credit_bound: assert property (@(posedge clk) disable iff (rst)
    (SUM_W'(fifo_count) + SUM_W'(inflight_q)) <= SUM_W'(FIFO_DEPTH));
  capture_tracked: assert property (@(posedge clk) disable iff (rst)
    capture |-> (inflight_q != '0));
endmodule

// File: tb/tb_aes_word_feeder.sv
// Feeder bench with a behavioural AES-128 core and a result scoreboard.
module tb_aes_word_feeder;
  import aes_feed_pkg::*;

  localparam int CL    = 21;
  localparam int DEPTH = 4;
  localparam logic [127:0] K_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_F = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_F = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_word_feeder_if ifc ();

  aes_word_feeder #(.CORE_LATENCY(CL), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [127:0]  sb_q [$];
  int            b2b   = 0;
  int            stale = 0;
  logic [7:0]    sbox [256];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s  [16];
    logic [7:0]   t  [16];
    logic [7:0]   rk [16];
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      rk[i] = key[127-8*i -: 8];
      s[i]  = pt[127-8*i -: 8] ^ rk[i];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      rk[0] = rk[0] ^ sbox[rk[13]] ^ rc;
      rk[1] = rk[1] ^ sbox[rk[14]];
      rk[2] = rk[2] ^ sbox[rk[15]];
      rk[3] = rk[3] ^ sbox[rk[12]];
      for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = sbox[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ rk[4*c+r];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] p;
      p = 8'h01;
      for (int k = 0; k < 254; k++) p = gm(p, 8'(x));
      sbox[x] = p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3) ^ rotl(p, 4) ^ 8'h63;
    end
  end

  // Core model: the edge that updates core_state/core_key is the first of CL edges.
  logic [127:0] core_pipe [CL-1];
  always @(posedge clk) begin
    for (int i = CL-2; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
    core_pipe[0] <= aes_enc(ifc.core_state, ifc.core_key);
  end
  assign ifc.core_out = core_pipe[CL-2];

  // Scoreboard pop on every accepted output; also flags stalls and stale results.
  initial begin
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev_ov = 1'b0;
      else begin
        if (ifc.out_valid) stale++;
        if (ifc.out_valid && ifc.out_ready && prev_ov) b2b++;
        if (ifc.out_valid && ifc.out_ready) begin
          if (sb_q.size() == 0) chk("sb_extra", 128'(sb_q.size()), 128'd1);
          else                  chk("sb_data", ifc.out_data, sb_q.pop_front());
        end
        prev_ov = ifc.out_valid & ifc.out_ready;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_word(input logic [31:0] d);
    int n;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    forever begin
      @(negedge clk);
      if (ifc.in_ready) break;
      n++;
      if (n > 300) begin
        chk("in_ready_timeout", 128'(n), 128'd0);
        break;
      end
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] pt, input logic [127:0] key, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send_word(pt[127-32*i -: 32]);
      if (gap && i < 3) begin @(posedge clk); #1; end
    end
    sb_q.push_back(aes_enc(pt, key));
  endtask

  task automatic set_key(input logic [127:0] k);
    ifc.key_load = 1'b1;
    ifc.key_in   = k;
    @(posedge clk); #1;
    ifc.key_load = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    chk("drain", 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    int n;
    logic [127:0] p;
    ifc.key_load = 1'b0; ifc.key_in = '0; ifc.in_valid = 1'b0;
    ifc.in_data  = '0;   ifc.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",   128'(ifc.in_ready),  128'd0);
    chk("rst_out_valid",  128'(ifc.out_valid), 128'd0);
    chk("rst_core_state", ifc.core_state,      128'd0);
    chk("rst_core_key",   ifc.core_key,        128'd0);
    chk("rst_inflight",   128'(ifc.inflight),  128'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("rdy_before_edge", 128'(ifc.in_ready), 128'd0);
    @(negedge clk); chk("rdy_after_edge",  128'(ifc.in_ready), 128'd1);
    @(posedge clk); #1;

    // FIPS-197 vector and issue-to-out_valid latency
    set_key(K_A);
    send_block(PT_F, K_A, 0);
    n = 0;
    while (n <= CL + 5) begin
      @(negedge clk);
      if (ifc.out_valid) break;
      if (n == 1) begin
        chk("fips_core_state", ifc.core_state,     PT_F);
        chk("fips_core_key",   ifc.core_key,       K_A);
        chk("fips_inflight1",  128'(ifc.inflight), 128'd1);
      end
      @(posedge clk); n++;
    end
    chk("fips_latency", 128'(n), 128'(CL + 1));
    chk("fips_ct", ifc.out_data, CT_F);
    @(posedge clk); #1 ifc.out_ready = 1'b1;
    drain(50);

    // Back-pressure: only FIFO_DEPTH blocks may issue
    ifc.out_ready = 1'b0;
    for (int b = 0; b < 5; b++) send_block(rnd128(), K_A, 0);
    @(negedge clk);
    chk("bp_inflight4", 128'(ifc.inflight), 128'd4);
    repeat (CL + 10) @(posedge clk);
    @(negedge clk);
    chk("bp_pend_in_ready", 128'(ifc.in_ready),  128'd0);
    chk("bp_inflight0",     128'(ifc.inflight),  128'd0);
    chk("bp_out_valid",     128'(ifc.out_valid), 128'd1);
    @(posedge clk); #1 ifc.out_ready = 1'b1;
    send_block(rnd128(), K_A, 0);
    drain(200);

    // Key change coinciding with an issue
    p = rnd128();
    send_block(p, K_A, 0);
    drain(60);
    send_block(p, K_A, 0);
    set_key(K_B);
    drain(60);
    send_block(p, K_B, 0);
    drain(60);

    // Streaming with the consumer always ready
    b2b = 0;
    for (int b = 0; b < 20; b++) send_block(rnd128(), K_B, 0);
    drain(200);
    chk("stream_no_stall", 128'(b2b), 128'd0);

    // Reset with one buffered and two in flight
    ifc.out_ready = 1'b0;
    send_block(rnd128(), K_B, 0);
    n = 0;
    while (!ifc.out_valid && n < CL + 10) begin @(posedge clk); #1; n++; end
    send_block(rnd128(), K_B, 0);
    send_block(rnd128(), K_B, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_inflight",  128'(ifc.inflight),  128'd2);
    chk("pre_rst_out_valid", 128'(ifc.out_valid), 128'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid",  128'(ifc.out_valid), 128'd0);
    chk("mid_rst_inflight",   128'(ifc.inflight),  128'd0);
    chk("mid_rst_core_state", ifc.core_state,      128'd0);
    chk("mid_rst_in_ready",   128'(ifc.in_ready),  128'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stale = 0;
    repeat (2 * CL) @(posedge clk);
    #1 chk("post_rst_stale", 128'(stale), 128'd0);
    ifc.out_ready = 1'b1;
    set_key(K_A);
    send_block(PT_F, K_A, 0);
    drain(60);

    // Slow source: in_valid toggles every other cycle
    send_block(rnd128(), K_A, 1);
    send_block(rnd128(), K_A, 1);
    drain(80);

    chk("sb_final_empty", 128'(sb_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
